// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Imported by the stage controller and its lane-alignment helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_e;

  localparam logic [7:0] BE_ALL = 8'hFF;
  localparam int         LANE_W = 3;

  typedef logic [LANE_W-1:0] lane_t;

  // Memory is doubleword-addressed; the low three bits only select a byte lane.
  function automatic logic [63:0] dw_align(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// The stage is the master; the memory (or a bench model) is the slave.
interface mem_stage_ctrl_if;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for LDURB/STURB: store replication and byte enables,
// and zero-extended extraction of the addressed byte on loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic        byte_op,
  input  lane_t       lane,
  input  logic [63:0] store_data,
  input  logic [63:0] rdata,
  output logic [7:0]  be,
  output logic [63:0] wdata,
  output logic [63:0] load_data
);

  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    be        = BE_ALL;
    wdata     = store_data;
    load_data = rdata;
    if (byte_op) begin
      be        = 8'b1 << lane;
      wdata     = {8{store_data[7:0]}};
      load_data = {56'b0, rdata[{lane, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage of the 64-bit pipeline: issues data-memory accesses over a
// req/ack bus, stalls while one is outstanding, and forms MEM/WB values.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8      // 2**CNT_W must exceed TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        RegWrite,
  input  logic        ByteOp,
  input  logic [4:0]  Rd,
  input  logic [63:0] ALUResult,
  input  logic [63:0] StoreData,
  output logic        stall,
  output logic        RegWrite_out,
  output logic [4:0]  Rd_out,
  output logic [63:0] WriteData_out,
  mem_stage_ctrl_if.master bus,
  output logic        align_err,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [63:0]      load_buf;
  logic             kill;

  logic             mem_req_q;
  logic             mem_we_q;
  logic [63:0]      mem_addr_q;
  logic [63:0]      mem_wdata_q;
  logic [7:0]       mem_be_q;

  logic             memop;
  logic             misaligned;
  logic             start;
  logic [7:0]       lane_be;
  logic [63:0]      lane_wdata;
  logic [63:0]      lane_load;

  assign memop      = ex_valid & (MemRead | MemWrite);
  assign misaligned = memop & ~ByteOp & (ALUResult[2:0] != 3'b000);
  assign start      = memop & ~misaligned;

  // Inputs are held stable through WAIT and DONE, so the live lane is valid at ack time.
  mem_lane_align u_lane_align (
    .byte_op    (ByteOp),
    .lane       (ALUResult[2:0]),
    .store_data (StoreData),
    .rdata      (bus.mem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      load_buf    <= '0;
      kill        <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          align_err <= misaligned;
          if (start) begin
            state       <= WAIT;
            mem_req_q   <= 1'b1;
            wait_cnt    <= '0;
            mem_we_q    <= MemWrite;
            mem_addr_q  <= dw_align(ALUResult);
            mem_wdata_q <= lane_wdata;
            mem_be_q    <= lane_be;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          // An ack arriving on the timeout cycle still completes the access.
          if (bus.mem_ack) begin
            load_buf  <= lane_load;
            mem_req_q <= 1'b0;
            state     <= DONE;
          end else if (wait_cnt == CNT_LAST) begin
            mem_req_q   <= 1'b0;
            timeout_err <= 1'b1;
            kill        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
          kill  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Non-memory instructions bypass combinationally; memory ops retire in DONE.
  always_comb begin
    stall         = 1'b0;
    RegWrite_out  = 1'b0;
    Rd_out        = Rd;
    WriteData_out = ALUResult;
    case (state)
      IDLE: begin
        stall        = start;
        RegWrite_out = ex_valid & RegWrite & ~memop;
      end
      WAIT: stall = 1'b1;
      DONE: begin
        RegWrite_out = RegWrite & ~kill;
        if (MemToReg) WriteData_out = load_buf;
      end
      default: ;
    endcase
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: randomized instruction stream, a
// responding memory model, and monitors checking commits, requests and error pulses.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, mem_read, mem_write, mem_to_reg, reg_write, byte_op;
  logic [4:0]  rd;
  logic [63:0] alu_result, store_data;
  logic        stall, reg_write_out, align_err, timeout_err;
  logic [4:0]  rd_out;
  logic [63:0] write_data_out;

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .MemRead       (mem_read),
    .MemWrite      (mem_write),
    .MemToReg      (mem_to_reg),
    .RegWrite      (reg_write),
    .ByteOp        (byte_op),
    .Rd            (rd),
    .ALUResult     (alu_result),
    .StoreData     (store_data),
    .stall         (stall),
    .RegWrite_out  (reg_write_out),
    .Rd_out        (rd_out),
    .WriteData_out (write_data_out),
    .bus           (bus),
    .align_err     (align_err),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v, ld, st, m2r, rw, bop;
    logic [4:0]  rd;
    logic [63:0] alu, sd, rdata;
    int          d;   // WAIT cycles without ack before the ack; >= TIMEOUT means never
  } instr_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic        chk;
  } commit_t;

  typedef struct {
    logic        we;
    logic [63:0] addr, wdata;
    logic [7:0]  be;
    int          d;
    logic [63:0] rdata;
    int          cycles;
  } req_t;

  typedef enum int {EV_ALIGN, EV_TIMEOUT} ev_e;

  commit_t commit_q[$];
  req_t    req_q[$];
  ev_e     ev_q[$];

  int   n_cmp = 0;
  int   n_fail = 0;
  bit   live = 1'b0;
  logic force_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not accounted for at %0t", name, $time);
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  function automatic instr_t mk(input logic v, ld, st, m2r, rw, bop, input logic [4:0] r,
                                input logic [63:0] alu, sd, rdata, input int d);
    instr_t i;
    i.v = v; i.ld = ld; i.st = st; i.m2r = m2r; i.rw = rw; i.bop = bop;
    i.rd = r; i.alu = alu; i.sd = sd; i.rdata = rdata; i.d = d;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    int kind;
    kind    = $urandom_range(2);             // 0 ALU, 1 load, 2 store
    i.v     = ($urandom_range(7) != 0);
    i.ld    = (kind == 1);
    i.st    = (kind == 2);
    i.m2r   = (kind == 1);
    i.rw    = (kind == 2) ? 1'b0 : 1'($urandom_range(1));
    i.bop   = 1'($urandom_range(1));
    i.rd    = 5'($urandom);
    i.alu   = {$urandom, $urandom};
    if (kind != 0 && !i.bop && $urandom_range(3) != 0) i.alu[2:0] = 3'b000;
    i.sd    = {$urandom, $urandom};
    i.rdata = {$urandom, $urandom};
    i.d     = ($urandom_range(9) == 0) ? TIMEOUT + 3 : int'($urandom_range(3));
    return i;
  endfunction

  task automatic drive(input instr_t i);
    ex_valid   = i.v;
    mem_read   = i.ld;
    mem_write  = i.st;
    mem_to_reg = i.m2r;
    reg_write  = i.rw;
    byte_op    = i.bop;
    rd         = i.rd;
    alu_result = i.alu;
    store_data = i.sd;
  endtask

  // Reference model: derive every observable consequence of one instruction.
  task automatic issue(input instr_t in);
    commit_t c;
    req_t    r;
    logic    memop, mis, timed;
    int      k, exp_sc, sc;
    memop  = in.v & (in.ld | in.st);
    mis    = memop & ~in.bop & (in.alu[2:0] != 3'b000);
    timed  = (in.d >= TIMEOUT);
    k      = int'(in.alu[2:0]);
    c.rd   = in.rd;
    c.wd   = in.alu;
    c.chk  = 1'b1;
    exp_sc = 0;
    if (!memop) begin
      c.rw = in.v & in.rw;
    end else if (mis) begin
      c.rw  = 1'b0;
      c.chk = 1'b0;
      ev_q.push_back(EV_ALIGN);
    end else begin
      c.rw = in.rw & ~timed;
      if (in.m2r) begin
        if (timed) c.chk = 1'b0;
        else c.wd = in.bop ? ((in.rdata >> (8 * k)) & 64'hFF) : in.rdata;
      end
      r.we     = in.st;
      r.addr   = in.alu & ~64'h7;
      r.be     = in.bop ? 8'(1 << k) : 8'hFF;
      r.wdata  = in.bop ? {56'b0, in.sd[7:0]} * 64'h0101_0101_0101_0101 : in.sd;
      r.d      = in.d;
      r.rdata  = in.rdata;
      r.cycles = timed ? TIMEOUT : in.d + 1;
      req_q.push_back(r);
      if (timed) ev_q.push_back(EV_TIMEOUT);
      exp_sc = 1 + r.cycles;
    end
    commit_q.push_back(c);

    @(posedge clk);
    #1;
    drive(in);
    live = 1'b1;
    sc = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      sc++;
      if (sc > 2 * TIMEOUT + 10) begin
        fail_now("stall_bound");
        finish_run();
      end
    end
    check("stall_cycles", 64'(sc), 64'(exp_sc));
  endtask

  // Memory responder and request checker.
  initial begin : responder
    req_t cur;
    bit   in_req;
    int   c;
    in_req        = 1'b0;
    c             = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!live) begin
        in_req        = 1'b0;
        bus.mem_ack   = force_ack;
        bus.mem_rdata = {$urandom, $urandom};
      end else if (bus.mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          c = 0;
          if (req_q.size() == 0) begin
            fail_now("req_unexpected");
            cur.d = 0;
            cur.cycles = 1;
            cur.rdata = '0;
          end else begin
            cur = req_q.pop_front();
            check("mem_we", bus.mem_we, cur.we);
            check("mem_addr", bus.mem_addr, cur.addr);
            check("mem_be", bus.mem_be, cur.be);
            check("mem_wdata", bus.mem_wdata, cur.wdata);
          end
        end else begin
          c++;
        end
        bus.mem_ack   = (c == cur.d);
        bus.mem_rdata = (c == cur.d) ? cur.rdata : {$urandom, $urandom};
      end else begin
        if (in_req) begin
          check("mem_req_cycles", 64'(c + 1), 64'(cur.cycles));
          in_req = 1'b0;
        end
        // Spurious acks outside WAIT must be ignored by the stage.
        bus.mem_ack   = ($urandom_range(3) == 0);
        bus.mem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin : commit_monitor
    commit_t c;
    forever begin
      @(negedge clk);
      if (live && !stall) begin
        if (commit_q.size() == 0) begin
          fail_now("commit_unexpected");
        end else begin
          c = commit_q.pop_front();
          check("reg_write_out", reg_write_out, c.rw);
          if (c.chk) begin
            check("rd_out", rd_out, c.rd);
            check("write_data_out", write_data_out, c.wd);
          end
        end
      end
    end
  end

  initial begin : event_monitor
    ev_e e;
    forever begin
      @(negedge clk);
      if (live && (align_err || timeout_err)) begin
        if (ev_q.size() == 0) begin
          fail_now(align_err ? "align_err_unexpected" : "timeout_err_unexpected");
        end else begin
          e = ev_q.pop_front();
          if (align_err) check("align_err_event", 64'(int'(e)), 64'(int'(EV_ALIGN)));
          else check("timeout_err_event", 64'(int'(e)), 64'(int'(EV_TIMEOUT)));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    fail_now("watchdog");
    finish_run();
  end

  initial begin : main
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0));
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 64'h0);
    check("rst_mem_wdata", bus.mem_wdata, 64'h0);
    check("rst_mem_be", bus.mem_be, 8'h00);
    check("rst_align_err", align_err, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases: ADD, LDUR, STURB, LDURB, misaligned LDUR, timed-out LDUR.
    issue(mk(1, 0, 0, 0, 1, 0, 5'd5, 64'h1234, 64'h0, 64'h0, 0));
    issue(mk(1, 1, 0, 1, 1, 0, 5'd9, 64'h100, 64'h0, 64'hDEADBEEF_CAFEF00D, 0));
    issue(mk(1, 0, 1, 0, 0, 1, 5'd3, 64'h203, 64'hAB, 64'h0, 1));
    issue(mk(1, 1, 0, 1, 1, 1, 5'd4, 64'h105, 64'h0, 64'h0011223344556677, 2));
    issue(mk(1, 1, 0, 1, 1, 0, 5'd6, 64'h104, 64'h0, 64'h0, 0));
    issue(mk(1, 1, 0, 1, 1, 0, 5'd7, 64'h108, 64'h0, 64'h0, TIMEOUT + 5));
    issue(mk(1, 0, 0, 0, 1, 0, 5'd8, 64'h77, 64'h0, 64'h0, 0));

    for (int n = 0; n < 300; n++) issue(rand_instr());
    issue(mk(1, 0, 0, 0, 1, 0, 5'd1, 64'h42, 64'h0, 64'h0, 0));
    @(posedge clk);
    live = 1'b0;

    check("commit_q_drained", 64'(commit_q.size()), 64'd0);
    check("req_q_drained", 64'(req_q.size()), 64'd0);
    check("ev_q_drained", 64'(ev_q.size()), 64'd0);

    // Reset in the middle of an access, then a late ack with the stage idle.
    @(posedge clk);
    #1;
    drive(mk(1, 1, 0, 1, 1, 0, 5'd2, 64'h300, 64'h0, 64'h0, 0));
    @(posedge clk);
    #1;
    check("wait_mem_req", bus.mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_mem_req", bus.mem_req, 1'b0);
    check("midrst_stall_load", stall, 1'b1);
    drive(mk(0, 0, 0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 64'h0, 0));
    #1;
    check("midrst_stall_bubble", stall, 1'b0);
    force_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk);
      #1;
      check("late_ack_mem_req", bus.mem_req, 1'b0);
      check("late_ack_stall", stall, 1'b0);
      check("late_ack_timeout", timeout_err, 1'b0);
    end
    force_ack = 1'b0;
    drive(mk(1, 0, 0, 0, 1, 0, 5'd7, 64'h55, 64'h0, 64'h0, 0));
    #1;
    check("post_rst_reg_write", reg_write_out, 1'b1);
    check("post_rst_rd", rd_out, 5'd7);
    check("post_rst_wdata", write_data_out, 64'h55);

    finish_run();
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory-access stage of the 64-bit pipelined CPU, between the EX/MEM pipeline register (upstream) and the MEM/WB register (downstream).
- Issues LDUR/STUR/LDURB/STURB accesses to data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding, and forms the RegWrite, Rd and WriteData values registered by MEM/WB.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles without mem_ack before the access is abandoned.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- MemRead  in  1  load.
- MemWrite  in  1  store.
- MemToReg  in  1  write-back source: 1 = load data, 0 = ALUResult.
- RegWrite  in  1  instruction writes Rd.
- ByteOp  in  1  1 = byte access (LDURB/STURB), 0 = doubleword.
- Rd  in  5  destination register.
- ALUResult  in  64  effective address, or result for non-memory instructions.
- StoreData  in  64  store source register value.
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- RegWrite_out  out  1  to MEM/WB.
- Rd_out  out  5  to MEM/WB.
- WriteData_out  out  64  to MEM/WB.
- mem_req  out  1  registered access request.
- mem_we  out  1  registered write enable.
- mem_addr  out  64  registered address, {ALUResult[63:3],3'b000}.
- mem_wdata  out  64  registered write data.
- mem_be  out  8  registered byte enables.
- mem_ack  in  1  memory completes the request this cycle; rdata valid.
- mem_rdata  in  64  read data.
- align_err  out  1  registered one-cycle pulse: misaligned doubleword access.
- timeout_err  out  1  registered one-cycle pulse: access abandoned.

Behaviour:
- States: IDLE, WAIT, DONE. Reset (asynchronous, reset==0) gives:
  - state = IDLE.
  - mem_req, mem_we, align_err, timeout_err = 0.
  - mem_addr, mem_wdata, mem_be, wait counter, load buffer = 0.
  - Reset mid-access drops mem_req immediately; a later mem_ack is ignored.
- IDLE, memop = ex_valid & (MemRead|MemWrite):
  - memop=0: stall=0. RegWrite_out=ex_valid&RegWrite, Rd_out=Rd, WriteData_out=ALUResult, all combinational.
  - memop=1, ByteOp=0, ALUResult[2:0]!=0: no request, stall=0, RegWrite_out=0 (instruction becomes a bubble), align_err pulses next cycle.
  - memop=1 otherwise: stall=1, RegWrite_out=0. Next edge: state=WAIT, mem_req=1, counter=0, and mem_we/mem_addr/mem_wdata/mem_be latched.
- WAIT:
  - stall=1, RegWrite_out=0, counter increments each cycle.
  - mem_ack=1: load buffer captures the sized mem_rdata; mem_req drops next edge; state=DONE.
  - Otherwise, counter==TIMEOUT-1: mem_req drops, timeout_err pulses, a kill flag is set, state=DONE.
- DONE:
  - stall=0, so EX/MEM advances at the end of this cycle.
  - RegWrite_out=RegWrite & ~kill, Rd_out=Rd.
  - WriteData_out = MemToReg ? load buffer : ALUResult.
  - Next edge: state=IDLE, kill=0.
- Contract: upstream holds all inputs stable while stall=1 and through DONE. mem_ack outside WAIT is ignored.
- Sizing:
  - Doubleword: mem_be=8'hFF, mem_wdata=StoreData, load = mem_rdata.
  - Byte: lane k=ALUResult[2:0]; mem_be=8'b1<<k; mem_wdata=StoreData[7:0] replicated to all 8 lanes; load = zero-extended mem_rdata[8k+7:8k].
- Latency: a memory op with ack in the first WAIT cycle occupies 3 cycles (IDLE, WAIT, DONE), i.e. 2 stall cycles. Each extra ack-wait cycle adds one.
- mem_ack and timeout in the same cycle: ack wins.

Decomposition:
- Shared package mem_pkg: state enum (IDLE/WAIT/DONE), BE_ALL=8'hFF, byte-lane index width 3.
- Natural sub-module: mem_lane_align (combinational). It does byte extract with zero-extend on loads, and byte replicate plus mem_be generation on stores.
- Registered fields use the existing regmodular/D_FF primitives.

Test Plan:
- ADD, ex_valid=1, RegWrite=1, Rd=5, ALUResult=64'h1234 -> same cycle: stall=0, RegWrite_out=1, Rd_out=5, WriteData_out=64'h1234, mem_req stays 0.
- LDUR at addr 64'h100, ack on first WAIT cycle, rdata=64'hDEADBEEF_CAFEF00D -> stall high 2 cycles; DONE: RegWrite_out=1, WriteData_out=64'hDEADBEEF_CAFEF00D; mem_addr=64'h100, mem_be=8'hFF.
- STURB addr 64'h203, StoreData=64'hAB -> mem_be=8'h08, mem_wdata=64'hABABABABABABABAB, mem_we=1; DONE: RegWrite_out=0.
- LDURB addr 64'h105, rdata=64'h0011223344556677 -> WriteData_out=64'h22; LDUR addr 64'h104 -> no mem_req, stall=0, align_err=1 for one cycle, RegWrite_out=0.
- TIMEOUT=4, LDUR with mem_ack never asserted -> mem_req high 4 cycles, timeout_err pulses once, DONE with RegWrite_out=0; late mem_ack in IDLE ignored.
- reset=0 while in WAIT -> mem_req=0 immediately, state IDLE, stall follows current inputs once reset=1.
